elm_neuron_mac: RTL and testbench

Hidden-layer neuron datapath that directly consumes the per-neuron weight memory. Accepts a stream of signed fixed-point inputs and drives the weight memory's read address and read enable. Multiplies each input by the weight returned one cycle later and accumulates the products with saturation. After `numWeight` products it adds the bias, applies ReLU, and emits one saturated result with a one-cycle valid pulse.

---
 rtl/elm_neuron_mac_if.sv | 31 +++
 rtl/elm_neuron_mac.sv | 141 ++++++++++++++
 tb/tb_elm_neuron_mac.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/elm_neuron_mac_if.sv
// elm_neuron_mac_if: bundles the input stream, bias, weight-memory read port and result of one
// hidden-layer neuron.
//   myinput/myinputValid : signed input sample stream (no backpressure)
//   bias                 : signed bias, static during a frame
//   raddr/ren            : weight memory read address / enable
//   wout                 : weight returned by memory one cycle after ren
//   out/outvalid         : neuron result and its one-cycle valid pulse
// slave is the neuron side; master is the side feeding inputs and hosting the weight memory.
interface elm_neuron_mac_if #(
  parameter int unsigned addressWidth = 10,
  parameter int unsigned dataWidth    = 16
);
  logic signed [dataWidth-1:0] myinput;
  logic                        myinputValid;
  logic signed [dataWidth-1:0] bias;
  logic        [addressWidth:0] raddr;
  logic                        ren;
  logic signed [dataWidth-1:0] wout;
  logic signed [dataWidth-1:0] out;
  logic                        outvalid;

  modport slave (
    input  myinput, myinputValid, bias, wout,
    output raddr, ren, out, outvalid
  );

  modport master (
    output myinput, myinputValid, bias, wout,
    input  raddr, ren, out, outvalid
  );
endinterface

// File: rtl/elm_neuron_mac.sv
// elm_neuron_mac: multiply-accumulate neuron reading its weights straight from memory.
// Each valid input is multiplied by the weight fetched for it, products are accumulated with
// saturation, and after numWeight products the bias is added, the result rescaled, clamped and
// passed through ReLU, and emitted with a one-cycle outvalid pulse.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : elm_neuron_mac_if.slave (input stream, bias, weight read port, result)
module elm_neuron_mac #(
  parameter int unsigned numWeight    = 784,
  parameter int unsigned addressWidth = 10,
  parameter int unsigned dataWidth    = 16,
  parameter int unsigned fracBits     = 8
) (
  input logic             clk,
  input logic             rst_n,
  elm_neuron_mac_if.slave bus
);

  localparam int unsigned AccW = 2 * dataWidth;
  localparam int unsigned RaW  = addressWidth + 1;
  localparam int unsigned CntW = (numWeight > 1) ? $clog2(numWeight) : 1;

  localparam logic [RaW-1:0]  LastAddr = RaW'(numWeight - 1);
  localparam logic [CntW-1:0] LastCnt  = CntW'(numWeight - 1);

  localparam logic signed [AccW-1:0] AccMax = {1'b0, {(AccW-1){1'b1}}};
  localparam logic signed [AccW-1:0] AccMin = {1'b1, {(AccW-1){1'b0}}};
  localparam logic signed [AccW-1:0] OutMax =
    {{(AccW-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};

  // Two's complement add clamped to the AccW range on overflow.
  function automatic logic signed [AccW-1:0] sat_add(input logic signed [AccW-1:0] a,
                                                      input logic signed [AccW-1:0] b);
    logic signed [AccW-1:0] s;
    s = a + b;
    if ((a[AccW-1] == b[AccW-1]) && (s[AccW-1] != a[AccW-1])) begin
      s = a[AccW-1] ? AccMin : AccMax;
    end
    return s;
  endfunction

  logic [RaW-1:0]                raddr_q, raddr_d;
  logic signed [dataWidth-1:0]   in_q, in_d;
  logic                          v1_q, v1_d;
  logic signed [AccW-1:0]        mul_q, mul_d;
  logic                          v2_q, v2_d;
  logic signed [AccW-1:0]        sum_q, sum_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic                          last_q, last_d;
  logic signed [dataWidth-1:0]   out_q, out_d;
  logic                          outvalid_q, outvalid_d;

  logic [AccW-1:0]               in_ext, w_ext, bias_ext;
  logic signed [AccW-1:0]        bias_sh, biased, shifted;
  logic signed [dataWidth-1:0]   result;

  assign bus.ren      = bus.myinputValid;
  assign bus.raddr    = raddr_q;
  assign bus.out      = out_q;
  assign bus.outvalid = outvalid_q;

  // Finalise path: sum + bias (both at 2*fracBits), rescale, clamp to dataWidth, ReLU.
  always_comb begin
    bias_ext = {{dataWidth{bus.bias[dataWidth-1]}}, bus.bias};
    bias_sh  = $signed(bias_ext) <<< fracBits;
    biased   = sat_add(sum_q, bias_sh);
    shifted  = biased >>> fracBits;
    if (shifted[AccW-1]) begin
      result = '0;
    end else if (shifted > OutMax) begin
      result = OutMax[dataWidth-1:0];
    end else begin
      result = shifted[dataWidth-1:0];
    end
  end

  always_comb begin
    raddr_d = raddr_q;
    if (bus.myinputValid) begin
      raddr_d = (raddr_q == LastAddr) ? '0 : raddr_q + RaW'(1);
    end

    in_d = bus.myinputValid ? bus.myinput : in_q;
    v1_d = bus.myinputValid;

    // Sign-extended operands: the low AccW bits of the product are the signed product.
    in_ext = {{dataWidth{in_q[dataWidth-1]}}, in_q};
    w_ext  = {{dataWidth{bus.wout[dataWidth-1]}}, bus.wout};
    mul_d  = $signed(in_ext * w_ext);
    v2_d   = v1_q;

    sum_d  = sum_q;
    cnt_d  = cnt_q;
    last_d = 1'b0;
    if (v2_q) begin
      sum_d = sat_add(sum_q, mul_q);
      if (cnt_q == LastCnt) begin
        cnt_d  = '0;
        last_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    out_d      = out_q;
    outvalid_d = 1'b0;
    if (last_q) begin
      out_d      = result;
      outvalid_d = 1'b1;
      // Next frame may already be producing: seed with its first product, never add to old sum.
      sum_d      = v2_q ? mul_q : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raddr_q    <= '0;
      in_q       <= '0;
      v1_q       <= 1'b0;
      mul_q      <= '0;
      v2_q       <= 1'b0;
      sum_q      <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      out_q      <= '0;
      outvalid_q <= 1'b0;
    end else begin
      raddr_q    <= raddr_d;
      in_q       <= in_d;
      v1_q       <= v1_d;
      mul_q      <= mul_d;
      v2_q       <= v2_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      out_q      <= out_d;
      outvalid_q <= outvalid_d;
    end
  end

endmodule

// File: tb/tb_elm_neuron_mac.sv
// tb_elm_neuron_mac: directed bench for elm_neuron_mac with numWeight=4, Q8.8 operands.
// Hosts a 4-entry weight memory model with one-cycle read latency.
module tb_elm_neuron_mac;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  elm_neuron_mac_if #(.addressWidth(10), .dataWidth(16)) bus ();

  elm_neuron_mac #(
    .numWeight   (4),
    .addressWidth(10),
    .dataWidth   (16),
    .fracBits    (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic signed [15:0] wmem [4];

  always @(posedge clk) begin
    if (bus.ren) bus.wout <= wmem[bus.raddr[1:0]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_w(input logic signed [15:0] w);
    for (int i = 0; i < 4; i++) wmem[i] = w;
  endtask

  // One frame of four identical inputs, optionally with a bubble after each of the first three.
  task automatic run_frame(input logic signed [15:0] x, input bit gap,
                           input logic [15:0] exp_out, input string tag);
    for (int i = 0; i < 4; i++) begin
      bus.myinput      = x;
      bus.myinputValid = 1'b1;
      check({tag, " raddr"}, 32'(bus.raddr), 32'(i));
      check({tag, " ren"}, 32'(bus.ren), 32'd1);
      step();
      if (gap && i < 3) begin
        bus.myinputValid = 1'b0;
        bus.myinput      = 16'sh7abc;
        check({tag, " raddr gap"}, 32'(bus.raddr), 32'(i + 1));
        check({tag, " ren gap"}, 32'(bus.ren), 32'd0);
        step();
      end
    end
    bus.myinputValid = 1'b0;
    bus.myinput      = '0;
    check({tag, " raddr wrap"}, 32'(bus.raddr), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      check({tag, " outvalid"}, 32'(bus.outvalid), 32'(k == 4));
      if (k >= 4) check({tag, " out"}, 32'(unsigned'(bus.out)), 32'(exp_out));
      if (k < 5) step();
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.myinput      = '0;
    bus.myinputValid = 1'b0;
    bus.bias         = '0;
    set_w(16'sd0);
    step();
    step();
    check("rst raddr", 32'(bus.raddr), 32'd0);
    check("rst out", 32'(unsigned'(bus.out)), 32'd0);
    check("rst outvalid", 32'(bus.outvalid), 32'd0);
    rst_n = 1'b1;

    // 4 * (1.0 * 2.0) + 0.5 = 8.5
    bus.bias = 16'sd128;
    set_w(16'sd512);
    run_frame(16'sd256, 1'b0, 16'd2176, "basic");

    // 4 * (1.0 * -1.0) + 0.5 < 0 -> ReLU 0
    set_w(-16'sd256);
    run_frame(16'sd256, 1'b0, 16'd0, "neg");

    // Accumulator and bias add saturate; narrowed result clamps to max
    set_w(16'sd32767);
    bus.bias = 16'sd32767;
    run_frame(16'sd32767, 1'b0, 16'd32767, "sat");

    // Alternate-cycle inputs, garbage while invalid
    bus.bias = 16'sd128;
    set_w(16'sd512);
    run_frame(16'sd256, 1'b1, 16'd2176, "gap");

    // Back-to-back frames: A (weights 2.0) then B (weights 1.0), no gap
    set_w(16'sd512);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) set_w(16'sd256);
      bus.myinput      = 16'sd256;
      bus.myinputValid = 1'b1;
      check("b2b raddr", 32'(bus.raddr), 32'(i % 4));
      step();
      check("b2b outvalid A", 32'(bus.outvalid), 32'(i == 6));
      if (i == 6) check("b2b out A", 32'(unsigned'(bus.out)), 32'd2176);
    end
    bus.myinputValid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      step();
      check("b2b outvalid B", 32'(bus.outvalid), 32'(k == 4));
      if (k >= 4) check("b2b out B", 32'(unsigned'(bus.out)), 32'd1152);
    end

    // Reset after two of four inputs discards the partial frame
    set_w(16'sd512);
    for (int i = 0; i < 2; i++) begin
      bus.myinput      = 16'sd256;
      bus.myinputValid = 1'b1;
      step();
    end
    bus.myinputValid = 1'b0;
    rst_n            = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst raddr", 32'(bus.raddr), 32'd0);
    check("midrst out", 32'(unsigned'(bus.out)), 32'd0);
    for (int k = 0; k < 6; k++) begin
      check("midrst outvalid", 32'(bus.outvalid), 32'd0);
      step();
    end
    run_frame(16'sd256, 1'b0, 16'd2176, "postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
